// File: rtl/sem_arb_pkg.sv
// Shared types and helpers for the semaphore-slot arbiter.
package sem_arb_pkg;

    typedef enum logic {
        SEM_ARB_EMPTY = 1'b0,
        SEM_ARB_FULL  = 1'b1
    } sem_arb_state_e;

    // Width of a requester index; never below 1 so a 2-requester build still has a bit.
    function automatic int sem_arb_id_w(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/sem_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module sem_rr_picker
    import sem_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = sem_arb_id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    int              cand;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                idx             = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sem_mem_arbiter.sv
// One-slot semaphore arbiter: N_REQ producers share a 1-bit slot drained by one consumer.
// Optional consumer timeout is compiled in with SEM_ARB_TIMEOUT_EN.
module sem_mem_arbiter
    import sem_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 16,
    localparam int ID_W    = sem_arb_id_w(N_REQ)
) (
    input  logic             clk_s,
    input  logic             rst_s,
    input  logic [N_REQ-1:0] req_write_i,
    input  logic [N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0] req_grant_o,
    output logic             sema_valid_o,
    output logic             sema_data_o,
    output logic [ID_W-1:0]  sema_src_o,
    input  logic             sema_ready_i,
    output logic             sema_drop_o
);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("sem_mem_arbiter: N_REQ out of range 2..16");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("sem_mem_arbiter: TIMEOUT out of range 2..255");
    end

    sem_arb_state_e   state;
    sem_arb_state_e   state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [N_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic             accept;
    logic             expire;

    sem_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req   (req_write_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grants only leave the block while the slot is empty and reset is low.
    assign accept      = (state == SEM_ARB_EMPTY) && !rst_s && pick_found;
    assign req_grant_o = accept ? pick_grant : '0;
    assign ptr_nxt     = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + ID_W'(1);

`ifdef SEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign expire = (state == SEM_ARB_FULL) && !sema_ready_i
                    && (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == SEM_ARB_FULL && !sema_ready_i) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // A reset landing on the expiry cycle discards the bit silently.
    assign sema_drop_o  = expire && !rst_s;
    assign sema_valid_o = (state == SEM_ARB_FULL);

    always_comb begin
        state_nxt = state;
        case (state)
            SEM_ARB_EMPTY: if (accept) state_nxt = SEM_ARB_FULL;
            SEM_ARB_FULL:  if (sema_ready_i || expire) state_nxt = SEM_ARB_EMPTY;
            default:       state_nxt = SEM_ARB_EMPTY;
        endcase
    end

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            state       <= SEM_ARB_EMPTY;
            ptr         <= '0;
            sema_data_o <= 1'b0;
            sema_src_o  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr         <= ptr_nxt;
                sema_data_o <= req_data_i[pick_idx];
                sema_src_o  <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_sem_mem_arbiter.sv
// Directed bench for sem_mem_arbiter with a slot-level reference model checked every cycle.
module tb_sem_mem_arbiter;
    import sem_arb_pkg::*;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;
    localparam int ID_W    = sem_arb_id_w(N_REQ);

    logic             clk_s = 1'b0;
    logic             rst_s;
    logic [N_REQ-1:0] req_write_i;
    logic [N_REQ-1:0] req_data_i;
    logic [N_REQ-1:0] req_grant_o;
    logic             sema_valid_o;
    logic             sema_data_o;
    logic [ID_W-1:0]  sema_src_o;
    logic             sema_ready_i;
    logic             sema_drop_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit mdl_en  = 1'b0;

    // Reference model: slot occupancy, stored bit/source, next-priority index, cycles waited.
    bit m_full = 1'b0, n_full = 1'b0;
    bit m_data = 1'b0, n_data = 1'b0;
    int m_src  = 0,    n_src  = 0;
    int m_ptr  = 0,    n_ptr  = 0;
    int m_wait = 0,    n_wait = 0;

    always #5 clk_s = ~clk_s;

    sem_mem_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_s        (clk_s),
        .rst_s        (rst_s),
        .req_write_i  (req_write_i),
        .req_data_i   (req_data_i),
        .req_grant_o  (req_grant_o),
        .sema_valid_o (sema_valid_o),
        .sema_data_o  (sema_data_o),
        .sema_src_o   (sema_src_o),
        .sema_ready_i (sema_ready_i),
        .sema_drop_o  (sema_drop_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N_REQ-1:0] v, input int i);
        return ((v >> i) & N_REQ'(1)) != '0;
    endfunction

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    always @(negedge clk_s) begin
        logic [N_REQ-1:0] e_grant;
        bit               e_drop;
        int               g;
        int               j;
        e_grant = '0;
        e_drop  = 1'b0;
        g       = -1;
        if (!rst_s && !m_full) begin
            for (int k = 0; k < N_REQ; k++) begin
                j = (m_ptr + k) % N_REQ;
                if (g < 0 && bit_of(req_write_i, j)) g = j;
            end
        end
        if (g >= 0) e_grant = N_REQ'(1) << g;
`ifdef SEM_ARB_TIMEOUT_EN
        e_drop = !rst_s && m_full && !sema_ready_i && (m_wait == TIMEOUT - 1);
`endif
        if (mdl_en) begin
            check("m_grant", 32'(req_grant_o), 32'(e_grant));
            check("m_valid", 32'(sema_valid_o), 32'(m_full));
            check("m_drop", 32'(sema_drop_o), 32'(e_drop));
            if (m_full) begin
                check("m_data", 32'(sema_data_o), 32'(m_data));
                check("m_src", 32'(sema_src_o), 32'(m_src));
            end
        end
        n_full = m_full; n_data = m_data; n_src = m_src; n_ptr = m_ptr; n_wait = m_wait;
        if (rst_s) begin
            n_full = 1'b0; n_data = 1'b0; n_src = 0; n_ptr = 0; n_wait = 0;
        end else if (!m_full) begin
            if (g >= 0) begin
                n_full = 1'b1;
                n_data = bit_of(req_data_i, g);
                n_src  = g;
                n_ptr  = (g + 1) % N_REQ;
                n_wait = 0;
            end
        end else if (sema_ready_i || e_drop) begin
            n_full = 1'b0;
        end else begin
            n_wait = m_wait + 1;
        end
    end

    always @(posedge clk_s) begin
        m_full <= n_full; m_data <= n_data; m_src <= n_src; m_ptr <= n_ptr; m_wait <= n_wait;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_s = 1'b1; req_write_i = '0; req_data_i = '0; sema_ready_i = 1'b0;
        tick();
        mdl_en = 1'b1;
        req_write_i = 4'b1111;
        @(negedge clk_s);
        check("rst_grant", 32'(req_grant_o), 32'h0);
        check("rst_valid", 32'(sema_valid_o), 32'h0);
        check("rst_src", 32'(sema_src_o), 32'h0);
        check("rst_data", 32'(sema_data_o), 32'h0);
        tick();

        // Two requesters, one transfer every two cycles.
        rst_s = 1'b0; req_write_i = 4'b0101; req_data_i = 4'b0001; sema_ready_i = 1'b1;
        @(negedge clk_s); check("r30_g0", 32'(req_grant_o), 32'b0001);
        tick(); req_write_i = 4'b0100;
        @(negedge clk_s);
        check("r30_v0", 32'(sema_valid_o), 32'h1);
        check("r30_s0", 32'(sema_src_o), 32'h0);
        check("r30_d0", 32'(sema_data_o), 32'h1);
        check("r30_nog", 32'(req_grant_o), 32'h0);
        tick();
        @(negedge clk_s); check("r30_g1", 32'(req_grant_o), 32'b0100);
        tick(); req_write_i = '0;
        @(negedge clk_s);
        check("r30_s1", 32'(sema_src_o), 32'h2);
        check("r30_d1", 32'(sema_data_o), 32'h0);
        tick();
        @(negedge clk_s); check("r30_empty", 32'(sema_valid_o), 32'h0);
        tick();

        // All requesters held: strict rotation 0,1,2,3,0.
        rst_s = 1'b1; req_write_i = '0;
        tick();
        rst_s = 1'b0; req_write_i = 4'b1111; req_data_i = 4'b1010; sema_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_s); check("r31_grant", 32'(req_grant_o), 32'(1) << (k % 4));
            tick();
            @(negedge clk_s);
            check("r31_src", 32'(sema_src_o), 32'(k % 4));
            check("r31_data", 32'(sema_data_o), 32'(k % 2));
            tick();
        end

        // Consumer stalls; waiting requester 3 is held off, slot contents stable.
        req_write_i = 4'b0010; req_data_i = 4'b0010; sema_ready_i = 1'b0;
        @(negedge clk_s); check("r32_fill", 32'(req_grant_o), 32'b0010);
        tick(); req_write_i = 4'b1000; req_data_i = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_s);
            check("r32_hold_g", 32'(req_grant_o), 32'h0);
            check("r32_hold_s", 32'(sema_src_o), 32'h1);
            check("r32_hold_d", 32'(sema_data_o), 32'h1);
            tick();
        end
        sema_ready_i = 1'b1;
        @(negedge clk_s); check("r32_xfer_g", 32'(req_grant_o), 32'h0);
        tick();
        @(negedge clk_s); check("r32_g3", 32'(req_grant_o), 32'b1000);
        tick(); req_write_i = '0;
        @(negedge clk_s); check("r32_s3", 32'(sema_src_o), 32'h3);
        tick();

        // Pointer moved to 3, then wrap to 0.
        req_write_i = 4'b0100;
        @(negedge clk_s); check("r35_g2", 32'(req_grant_o), 32'b0100);
        tick(); req_write_i = 4'b1001; req_data_i = 4'b1000;
        @(negedge clk_s); check("r35_s2", 32'(sema_src_o), 32'h2);
        tick();
        @(negedge clk_s); check("r35_g3", 32'(req_grant_o), 32'b1000);
        tick(); req_write_i = 4'b0001;
        @(negedge clk_s); check("r35_d3", 32'(sema_data_o), 32'h1);
        tick();
        @(negedge clk_s); check("r35_g0", 32'(req_grant_o), 32'b0001);
        tick(); req_write_i = '0;
        @(negedge clk_s); check("r35_s0", 32'(sema_src_o), 32'h0);
        tick();

        // Reset while full: bit discarded, no drop, pointer back to 0.
        req_write_i = 4'b0010; req_data_i = 4'b0010; sema_ready_i = 1'b0;
        @(negedge clk_s); check("r34_fill", 32'(req_grant_o), 32'b0010);
        tick(); req_write_i = '0;
        tick(); rst_s = 1'b1;
        @(negedge clk_s); check("r34_drop_rst", 32'(sema_drop_o), 32'h0);
        tick(); rst_s = 1'b0; req_write_i = 4'b1111;
        @(negedge clk_s);
        check("r34_valid", 32'(sema_valid_o), 32'h0);
        check("r34_src", 32'(sema_src_o), 32'h0);
        check("r34_data", 32'(sema_data_o), 32'h0);
        check("r34_drop", 32'(sema_drop_o), 32'h0);
        check("r34_ptr0", 32'(req_grant_o), 32'b0001);
        tick(); req_write_i = '0; sema_ready_i = 1'b1;
        @(negedge clk_s); check("r34_s0", 32'(sema_src_o), 32'h0);
        tick();

        // Consumer never answers.
        req_write_i = 4'b0001; req_data_i = 4'b0001; sema_ready_i = 1'b0;
        @(negedge clk_s); check("r33_fill", 32'(req_grant_o), 32'b0001);
        tick(); req_write_i = '0;
`ifdef SEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_s);
            check("r33_valid", 32'(sema_valid_o), 32'h1);
            check("r33_drop", 32'(sema_drop_o), 32'(k == 16));
            tick();
        end
        req_write_i = 4'b0001;
        @(negedge clk_s);
        check("r33_fell", 32'(sema_valid_o), 32'h0);
        check("r33_once", 32'(sema_drop_o), 32'h0);
        check("r33_refill", 32'(req_grant_o), 32'b0001);
        tick(); req_write_i = '0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) sema_ready_i = 1'b1;
            @(negedge clk_s);
            check("r33_nodrop", 32'(sema_drop_o), 32'h0);
            check("r33_valid2", 32'(sema_valid_o), 32'h1);
            tick();
        end
        @(negedge clk_s); check("r33_xfer", 32'(sema_valid_o), 32'h0);
        tick();
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_s);
            check("r27_valid", 32'(sema_valid_o), 32'h1);
            check("r27_drop", 32'(sema_drop_o), 32'h0);
            tick();
        end
        sema_ready_i = 1'b1;
        tick();
        @(negedge clk_s); check("r27_xfer", 32'(sema_valid_o), 32'h0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
